// File: rtl/pcie_ts_wr.sv
`default_nettype none
// ============================================================================
// Module   : pcie_ts_wr
// Purpose  : Packs 188-byte TS packets into 64-bit words, fixed 24-word slots,
//            written into a two-bank ping-pong RAM handed to the DMA reader.
// Revision : 1.0
// ============================================================================
module pcie_ts_wr #(
  parameter int PKTS_PER_BANK = 64,
  parameter int BANK_AW       = 11,
  parameter int FLUSH_CYC     = 27000
) (
  input  logic               clk_ts,
  input  logic               rst,
  input  logic [7:0]         ts_din,
  input  logic               ts_valid,
  input  logic               ts_sop,
  input  logic [1:0]         buf_release,
  output logic               ram_wr,
  output logic [BANK_AW:0]   ram_waddr,
  output logic [63:0]        ram_wdata,
  output logic [1:0]         bank_full,
  output logic               bank_done,
  output logic               bank_done_id,
  output logic [6:0]         bank_done_pkts,
  output logic [15:0]        drop_cnt,
  output logic [15:0]        err_cnt
);

  localparam int                IDLE_W    = $clog2(FLUSH_CYC + 1);
  localparam logic [7:0]        LAST_IDX  = 8'd187;
  localparam logic [6:0]        PKT_LAST  = 7'(PKTS_PER_BANK - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PACK = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                cur_q, cur_d;
  logic [6:0]          pkt_cnt_q, pkt_cnt_d;
  logic [7:0]          idx_q, idx_d;
  logic [63:0]         data_q, data_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                ram_wr_q, ram_wr_d;
  logic [BANK_AW:0]    ram_waddr_q, ram_waddr_d;
  logic [63:0]         ram_wdata_q, ram_wdata_d;
  logic [1:0]          bank_full_q, bank_full_d;
  logic                bank_done_q, bank_done_d;
  logic                done_id_q, done_id_d;
  logic [6:0]          done_pkts_q, done_pkts_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;
  logic [15:0]         err_cnt_q, err_cnt_d;

  logic                pkt_start;
  logic                pkt_take;
  logic                close_bank;
  logic [6:0]          close_pkts;
  logic [7:0]          idx;
  logic [63:0]         word;
  logic [BANK_AW-1:0]  word_addr;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    pkt_cnt_d   = pkt_cnt_q;
    idx_d       = idx_q;
    data_d      = data_q;
    idle_d      = '0;
    ram_wr_d    = 1'b0;
    ram_waddr_d = ram_waddr_q;
    ram_wdata_d = ram_wdata_q;
    bank_full_d = bank_full_q & ~buf_release;
    bank_done_d = 1'b0;
    done_id_d   = done_id_q;
    done_pkts_d = done_pkts_q;
    drop_cnt_d  = drop_cnt_q;
    err_cnt_d   = err_cnt_q;
    pkt_start   = 1'b0;
    pkt_take    = 1'b0;
    close_bank  = 1'b0;
    close_pkts  = pkt_cnt_q;

    case (state_q)
      PACK: begin
        if (ts_valid) begin
          if (ts_sop) begin
            // Early sop aborts the packet in flight; the new one reuses the slot.
            pkt_start = 1'b1;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          end else begin
            pkt_take = 1'b1;
          end
        end
      end
      default: begin
        if (ts_valid && ts_sop) begin
          if (bank_full_q[cur_q]) begin
            state_d = DROP;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
          end else begin
            pkt_start = 1'b1;
          end
        end
      end
    endcase

    idx       = pkt_start ? 8'd0 : idx_q;
    word      = data_q;
    word[{~idx[2:0], 3'b000} +: 8] = ts_din;
    word_addr = BANK_AW'(pkt_cnt_q) * BANK_AW'(24) + BANK_AW'(idx[7:3]);

    if (pkt_start || pkt_take) begin
      data_d  = word;
      idx_d   = idx + 8'd1;
      state_d = PACK;
      if (idx[2:0] == 3'd7) begin
        ram_wr_d    = 1'b1;
        ram_waddr_d = {cur_q, word_addr};
        ram_wdata_d = word;
      end
      if (idx == LAST_IDX) begin
        ram_wr_d    = 1'b1;
        ram_waddr_d = {cur_q, word_addr};
        ram_wdata_d = {word[63:32], 32'hFFFF_FFFF};
        state_d     = IDLE;
        idx_d       = 8'd0;
        if (pkt_cnt_q == PKT_LAST) begin
          close_bank = 1'b1;
          close_pkts = pkt_cnt_q + 7'd1;
        end else begin
          pkt_cnt_d = pkt_cnt_q + 7'd1;
        end
      end
    end

    // Idle flush timer runs only while a partially filled bank waits for more data.
    if ((state_q != PACK) && (pkt_cnt_q != 7'd0) && !pkt_start) begin
      if (idle_q == IDLE_LAST) close_bank = 1'b1;
      else                     idle_d     = idle_q + IDLE_W'(1);
    end

    if (close_bank) begin
      bank_full_d[cur_q] = 1'b1;
      bank_done_d        = 1'b1;
      done_id_d          = cur_q;
      done_pkts_d        = close_pkts;
      cur_d              = ~cur_q;
      pkt_cnt_d          = 7'd0;
    end
  end

  always_ff @(posedge clk_ts) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_q       <= 1'b0;
      pkt_cnt_q   <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      idle_q      <= '0;
      ram_wr_q    <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
      bank_full_q <= '0;
      bank_done_q <= 1'b0;
      done_id_q   <= 1'b0;
      done_pkts_q <= '0;
      drop_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      pkt_cnt_q   <= pkt_cnt_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      idle_q      <= idle_d;
      ram_wr_q    <= ram_wr_d;
      ram_waddr_q <= ram_waddr_d;
      ram_wdata_q <= ram_wdata_d;
      bank_full_q <= bank_full_d;
      bank_done_q <= bank_done_d;
      done_id_q   <= done_id_d;
      done_pkts_q <= done_pkts_d;
      drop_cnt_q  <= drop_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign ram_wr         = ram_wr_q;
  assign ram_waddr      = ram_waddr_q;
  assign ram_wdata      = ram_wdata_q;
  assign bank_full      = bank_full_q;
  assign bank_done      = bank_done_q;
  assign bank_done_id   = done_id_q;
  assign bank_done_pkts = done_pkts_q;
  assign drop_cnt       = drop_cnt_q;
  assign err_cnt        = err_cnt_q;

endmodule
`default_nettype wire
